// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for signed or unsigned operands, one Booth step per cycle.
// Latency WIDTH+2 cycles from start to done; no backpressure, and start is ignored unless idle.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   q_reg;
    logic [WIDTH:0]   m_reg;
    logic             qm1;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             last_step;

    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH:0]   q_nxt;

    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One extra guard bit on the add keeps A+/-M exact before the arithmetic shift.
    always_comb begin
        a_ext = {a_reg[WIDTH], a_reg};
        m_ext = {m_reg[WIDTH], m_reg};
        case ({q_reg[0], qm1})
            2'b01:   sum = a_ext + m_ext;
            2'b10:   sum = a_ext - m_ext;
            default: sum = a_ext;
        endcase
        a_nxt = sum[WIDTH+1:1];
        q_nxt = {sum[0], q_reg[WIDTH:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            m_reg <= is_signed ? {m[WIDTH-1], m} : {1'b0, m};
            q_reg <= is_signed ? {q[WIDTH-1], q} : {1'b0, q};
            a_reg <= '0;
            qm1   <= 1'b0;
            cnt   <= CNT_INIT;
        end else if (step) begin
            a_reg <= a_nxt;
            q_reg <= q_nxt;
            qm1   <= q_reg[0];
            cnt   <= cnt - CW'(1);
            if (last_step) begin
                product <= {a_nxt[WIDTH-2:0], q_nxt};
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of the sequential Booth multiplier at WIDTH 8, 4 and 16.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_signed;
    logic [7:0]  m, q;
    logic        busy, done;
    logic [15:0] product;

    logic        start4, s4, busy4, done4;
    logic [3:0]  m4, q4;
    logic [7:0]  product4;

    logic        start16, s16, busy16, done16;
    logic [15:0] m16, q16;
    logic [31:0] product16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .m(m), .q(q), .busy(busy), .done(done), .product(product)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(s4),
        .m(m4), .q(q4), .busy(busy4), .done(done4), .product(product4)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .is_signed(s16),
        .m(m16), .q(q16), .busy(busy16), .done(done16), .product(product16)
    );

    // Runs one WIDTH=8 operation from IDLE and reports what was observed over cycles 1..14.
    task automatic do_mult(input logic s, input logic [7:0] mm, input logic [7:0] qq,
                           output logic [15:0] prod, output int dcyc, output int npulse,
                           output int berr);
        prod = 16'hxxxx; dcyc = -1; npulse = 0; berr = 0;
        is_signed = s; m = mm; q = qq; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m = 8'($urandom); q = 8'($urandom); is_signed = ~s;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (busy !== (c <= 9) || (busy && done)) berr++;
            if (done === 1'b1) begin
                npulse++;
                if (dcyc < 0) begin dcyc = c; prod = product; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; is_signed = 1'b1; m = 8'h07; q = 8'h02;
        start4 = 1'b1; s4 = 1'b0; m4 = 4'h3; q4 = 4'h3;
        start16 = 1'b1; s16 = 1'b0; m16 = 16'h1234; q16 = 16'h0002;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
        checks++; if (busy4 !== 1'b0 || product4 !== 8'h00) begin errors++; $display("FAIL reset_w4: busy %b product %h expected 0 00", busy4, product4); end
        checks++; if (busy16 !== 1'b0 || product16 !== 32'h0) begin errors++; $display("FAIL reset_w16: busy %b product %h expected 0 0", busy16, product16); end
        rst = 1'b0; start = 1'b0; start4 = 1'b0; start16 = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_basic();
        logic        ts[6];
        logic [7:0]  tm[6], tq[6];
        logic [15:0] te[6];
        logic [15:0] p;
        int dc, np, be;
        ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tm = '{8'h07, 8'hF9, 8'hD8, 8'h80, 8'hFF, 8'h80};
        tq = '{8'h02, 8'h03, 8'h0F, 8'h80, 8'hFF, 8'h02};
        te = '{16'h000E, 16'hFFEB, 16'hFDA8, 16'h4000, 16'hFE01, 16'h0100};
        for (int i = 0; i < 6; i++) begin
            do_mult(ts[i], tm[i], tq[i], p, dc, np, be);
            checks++; if (p !== te[i]) begin errors++; $display("FAIL basic%0d_product: got %h expected %h", i, p, te[i]); end
            checks++; if (dc != 10) begin errors++; $display("FAIL basic%0d_done_cycle: got %0d expected 10", i, dc); end
            checks++; if (np != 1) begin errors++; $display("FAIL basic%0d_done_pulses: got %0d expected 1", i, np); end
            checks++; if (be != 0) begin errors++; $display("FAIL basic%0d_busy_pattern: got %0d bad cycles expected 0", i, be); end
        end
        do_mult(1'b1, 8'h80, 8'h02, p, dc, np, be);
        checks++; if (p !== 16'hFF00) begin errors++; $display("FAIL signed_80x02: got %h expected ff00", p); end
    endtask

    task automatic test_start_in_run();
        int dc = -1;
        int np = 0;
        logic [15:0] p = 16'hxxxx;
        is_signed = 1'b1; m = 8'h07; q = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 4) begin start = 1'b1; is_signed = 1'b0; m = 8'hFF; q = 8'hFF; end
            if (c == 5) start = 1'b0;
            if (done === 1'b1) begin
                np++;
                if (dc < 0) begin dc = c; p = product; end
            end
        end
        checks++; if (p !== 16'h000E) begin errors++; $display("FAIL run_start_product: got %h expected 000e", p); end
        checks++; if (dc != 10) begin errors++; $display("FAIL run_start_done_cycle: got %0d expected 10", dc); end
        checks++; if (np != 1) begin errors++; $display("FAIL run_start_pulses: got %0d expected 1", np); end
    endtask

    task automatic test_reset_abort();
        int np = 0;
        int dc, nq, be;
        logic [15:0] p;
        is_signed = 1'b1; m = 8'hD8; q = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_running: busy %b expected 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL abort_product: got %h expected 0000", product); end
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) np++;
        end
        checks++; if (np != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", np); end
        do_mult(1'b1, 8'hF9, 8'h03, p, dc, nq, be);
        checks++; if (p !== 16'hFFEB || dc != 10) begin errors++; $display("FAIL abort_restart: got %h at cycle %0d expected ffeb at 10", p, dc); end
    endtask

    task automatic test_back_to_back();
        logic        bs[3];
        logic [7:0]  bm[3], bq[3];
        logic [15:0] be[3];
        int          dcy[3];
        logic [15:0] pr[3];
        int k = 0;
        bs = '{1'b1, 1'b0, 1'b1};
        bm = '{8'h07, 8'hC8, 8'hFF};
        bq = '{8'h02, 8'h03, 8'hFF};
        be = '{16'h000E, 16'h0258, 16'h0001};
        dcy = '{-1, -1, -1};
        pr = '{16'hxxxx, 16'hxxxx, 16'hxxxx};
        is_signed = bs[0]; m = bm[0]; q = bq[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (done === 1'b1) begin
                if (k < 3) begin dcy[k] = c; pr[k] = product; end
                k++;
                if (k < 3) begin is_signed = bs[k]; m = bm[k]; q = bq[k]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (k != 3) begin errors++; $display("FAIL b2b_count: got %0d done pulses expected 3", k); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dcy[i] != 10 + 11 * i) begin errors++; $display("FAIL b2b%0d_cycle: got %0d expected %0d", i, dcy[i], 10 + 11 * i); end
            checks++; if (pr[i] !== be[i]) begin errors++; $display("FAIL b2b%0d_product: got %h expected %h", i, pr[i], be[i]); end
        end
    endtask

    task automatic test_width4();
        logic [3:0] a, b;
        logic       s, seen;
        logic [7:0] exp8, got;
        longint     e;
        int         cyc;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom); b = 4'($urandom); s = 1'($urandom);
            if (i == 0) begin a = 4'h8; b = 4'h8; s = 1'b1; end
            if (i == 1) begin a = 4'hF; b = 4'hF; s = 1'b0; end
            e = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
            exp8 = e[7:0];
            s4 = s; m4 = a; q4 = b; start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0; m4 = ~a; q4 = ~b;
            seen = 1'b0; cyc = 0; got = 8'hxx;
            while (!seen && cyc < 20) begin
                cyc++;
                if (done4 === 1'b1) begin seen = 1'b1; got = product4; end
                else begin @(posedge clk); #1; end
            end
            checks++; if (!seen || got !== exp8 || cyc != 6) begin errors++; $display("FAIL w4_%0d s=%b %h*%h: got %h at cycle %0d expected %h at 6", i, s, a, b, got, cyc, exp8); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_width16();
        logic [15:0] a, b;
        logic        s, seen;
        logic [31:0] exp32, got;
        longint      e;
        int          cyc;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            if (i == 0) begin a = 16'h8000; b = 16'h8000; s = 1'b1; end
            if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; s = 1'b0; end
            if (i == 2) begin a = 16'h8000; b = 16'h7FFF; s = 1'b1; end
            e = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
            exp32 = e[31:0];
            s16 = s; m16 = a; q16 = b; start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0; m16 = ~a; q16 = ~b;
            seen = 1'b0; cyc = 0; got = 32'hxxxx_xxxx;
            while (!seen && cyc < 30) begin
                cyc++;
                if (done16 === 1'b1) begin seen = 1'b1; got = product16; end
                else begin @(posedge clk); #1; end
            end
            checks++; if (!seen || got !== exp32 || cyc != 18) begin errors++; $display("FAIL w16_%0d s=%b %h*%h: got %h at cycle %0d expected %h at 18", i, s, a, b, got, cyc, exp32); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_in_run();
        test_reset_abort();
        test_back_to_back();
        test_width4();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
